// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two cache requesters, the memory port and the arbiter.
// The arbiter connects through 'slave'; the requester/memory environment uses 'master'.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          I_REQ;
    logic [AW-1:0] I_ADDR;
    logic          I_GNT;
    logic          I_RVALID;
    logic          I_DONE;

    logic          D_REQ;
    logic          D_WE;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic          D_GNT;
    logic          D_RVALID;
    logic          D_WNEXT;
    logic          D_DONE;

    logic [DW-1:0] RDATA;

    logic          M_REQ;
    logic          M_WE;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_WDATA;
    logic          M_READY;
    logic [DW-1:0] M_RDATA;

    logic          BUSY;

    modport slave (
        input  I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_READY, M_RDATA,
        output I_GNT, I_RVALID, I_DONE, D_GNT, D_RVALID, D_WNEXT, D_DONE,
               RDATA, M_REQ, M_WE, M_ADDR, M_WDATA, BUSY
    );

    modport master (
        output I_REQ, I_ADDR, D_REQ, D_WE, D_ADDR, D_WDATA, M_READY, M_RDATA,
        input  I_GNT, I_RVALID, I_DONE, D_GNT, D_RVALID, D_WNEXT, D_DONE,
               RDATA, M_REQ, M_WE, M_ADDR, M_WDATA, BUSY
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between I-cache refills and
// D-cache refills/writebacks, issuing each grant as a BEATS-word line burst.
module mem_port_arbiter #(
    parameter int BEATS = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    mem_port_arbiter_if.slave    bus
);
    localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int STEP_LG = $clog2(DW / 8);
    localparam int LINE_LG = $clog2(BEATS * (DW / 8));
    localparam logic [AW-1:0] LINE_MASK = {AW{1'b1}} << LINE_LG;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_beat;
    logic [AW-1:0] r_base;
    logic          r_ownerD;
    logic          r_we;
    logic          r_lastD;
    logic          r_iGnt;
    logic          r_dGnt;

    logic          w_inBurst;
    logic          w_inDone;
    logic          w_beatDone;
    logic          w_lastBeat;
    logic          w_grant;
    logic          w_pickD;

    assign w_inBurst  = (r_state == BURST);
    assign w_inDone   = (r_state == DONE);
    assign w_beatDone = w_inBurst && bus.M_READY;
    assign w_lastBeat = (r_beat == CW'(BEATS - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // On a tie the requester that did not own the previous burst wins.
    always_comb begin
        w_nextState = r_state;
        w_grant     = 1'b0;
        w_pickD     = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.I_REQ || bus.D_REQ) begin
                    w_grant     = 1'b1;
                    w_pickD     = (bus.I_REQ && bus.D_REQ) ? !r_lastD : bus.D_REQ;
                    w_nextState = BURST;
                end
            end
            BURST: begin
                if (w_beatDone && w_lastBeat) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_beat   <= '0;
            r_base   <= '0;
            r_ownerD <= 1'b0;
            r_we     <= 1'b0;
            r_lastD  <= 1'b0;
            r_iGnt   <= 1'b0;
            r_dGnt   <= 1'b0;
        end else begin
            if (w_grant) begin
                r_ownerD <= w_pickD;
                r_we     <= w_pickD && bus.D_WE;
                r_base   <= (w_pickD ? bus.D_ADDR : bus.I_ADDR) & LINE_MASK;
                r_iGnt   <= !w_pickD;
                r_dGnt   <= w_pickD;
                r_beat   <= '0;
            end
            if (w_beatDone) begin
                r_beat <= r_beat + CW'(1);
            end
            if (w_inDone) begin
                r_lastD <= r_ownerD;
                r_iGnt  <= 1'b0;
                r_dGnt  <= 1'b0;
            end
        end
    end

    assign bus.M_REQ    = w_inBurst;
    assign bus.M_WE     = w_inBurst && r_we;
    assign bus.M_ADDR   = w_inBurst ? (r_base + (AW'(r_beat) << STEP_LG)) : '0;
    assign bus.M_WDATA  = (w_inBurst && r_we) ? bus.D_WDATA : '0;
    assign bus.RDATA    = (w_inBurst && !r_we) ? bus.M_RDATA : '0;

    assign bus.I_GNT    = r_iGnt;
    assign bus.D_GNT    = r_dGnt;
    assign bus.I_RVALID = w_beatDone && !r_we && !r_ownerD;
    assign bus.D_RVALID = w_beatDone && !r_we && r_ownerD;
    assign bus.D_WNEXT  = w_beatDone && r_we;
    assign bus.I_DONE   = w_inDone && !r_ownerD;
    assign bus.D_DONE   = w_inDone && r_ownerD;
    assign bus.BUSY     = (r_state != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a vector table plus procedural burst sequences,
// each vector's expectation queued at drive time and checked before the next edge.
module tb_mem_port_arbiter;
    localparam logic [9:0] MREQ = 10'b1000000000;
    localparam logic [9:0] MWE  = 10'b0100000000;
    localparam logic [9:0] IGNT = 10'b0010000000;
    localparam logic [9:0] DGNT = 10'b0001000000;
    localparam logic [9:0] IRV  = 10'b0000100000;
    localparam logic [9:0] DRV  = 10'b0000010000;
    localparam logic [9:0] WNX  = 10'b0000001000;
    localparam logic [9:0] IDN  = 10'b0000000100;
    localparam logic [9:0] DDN  = 10'b0000000010;
    localparam logic [9:0] BSY  = 10'b0000000001;

    // care bits: [2] M_ADDR, [1] M_WDATA, [0] RDATA
    typedef struct {
        logic        rst;
        logic        iReq;
        logic        dReq;
        logic        dWe;
        logic        mReady;
        logic [31:0] iAddr;
        logic [31:0] dAddr;
        logic [31:0] dWdata;
        logic [31:0] mRdata;
        logic [9:0]  ctl;
        logic [31:0] eAddr;
        logic [31:0] eWdata;
        logic [31:0] eRdata;
        logic [2:0]  care;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   vecIdx = 0;

    vec_t expQ[$];
    vec_t tbl[$];

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.BEATS(4), .AW(32), .DW(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mkVec(
        input logic rst, input logic iReq, input logic dReq, input logic dWe,
        input logic mReady, input logic [31:0] iAddr, input logic [31:0] dAddr,
        input logic [31:0] dWdata, input logic [31:0] mRdata, input logic [9:0] ctl,
        input logic [31:0] eAddr, input logic [31:0] eWdata, input logic [31:0] eRdata,
        input logic [2:0] care);
        vec_t v;
        v.rst = rst;       v.iReq = iReq;     v.dReq = dReq;     v.dWe = dWe;
        v.mReady = mReady; v.iAddr = iAddr;   v.dAddr = dAddr;   v.dWdata = dWdata;
        v.mRdata = mRdata; v.ctl = ctl;       v.eAddr = eAddr;   v.eWdata = eWdata;
        v.eRdata = eRdata; v.care = care;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge CLK);
        RST         = v.rst;
        bus.I_REQ   = v.iReq;
        bus.I_ADDR  = v.iAddr;
        bus.D_REQ   = v.dReq;
        bus.D_WE    = v.dWe;
        bus.D_ADDR  = v.dAddr;
        bus.D_WDATA = v.dWdata;
        bus.M_READY = v.mReady;
        bus.M_RDATA = v.mRdata;
        expQ.push_back(v);
    endtask

    task automatic checkOutput();
        vec_t e;
        logic [9:0] act;
        #1;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard vec%0d: actual empty queue, required one entry", vecIdx);
        end else begin
            e = expQ.pop_front();
            act = {bus.M_REQ, bus.M_WE, bus.I_GNT, bus.D_GNT, bus.I_RVALID, bus.D_RVALID,
                   bus.D_WNEXT, bus.I_DONE, bus.D_DONE, bus.BUSY};
            checks++;
            if (act !== e.ctl) begin
                errors++;
                $display("[TB] FAIL ctl vec%0d: actual %b, required %b (MREQ MWE IGNT DGNT IRV DRV WNX IDN DDN BSY)",
                         vecIdx, act, e.ctl);
            end
            if (e.care[2]) begin
                checks++;
                if (bus.M_ADDR !== e.eAddr) begin
                    errors++;
                    $display("[TB] FAIL maddr vec%0d: actual %h, required %h", vecIdx, bus.M_ADDR, e.eAddr);
                end
            end
            if (e.care[1]) begin
                checks++;
                if (bus.M_WDATA !== e.eWdata) begin
                    errors++;
                    $display("[TB] FAIL mwdata vec%0d: actual %h, required %h", vecIdx, bus.M_WDATA, e.eWdata);
                end
            end
            if (e.care[0]) begin
                checks++;
                if (bus.RDATA !== e.eRdata) begin
                    errors++;
                    $display("[TB] FAIL rdata vec%0d: actual %h, required %h", vecIdx, bus.RDATA, e.eRdata);
                end
            end
        end
        vecIdx++;
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        checkOutput();
    endtask

    initial begin
        logic [31:0] wd;
        logic        rdy;
        logic        dReq;
        int          beat;

        bus.I_REQ = 1'b0;  bus.I_ADDR = '0;  bus.D_REQ = 1'b0;  bus.D_WE = 1'b0;
        bus.D_ADDR = '0;   bus.D_WDATA = '0; bus.M_READY = 1'b0; bus.M_RDATA = '0;

        // Single instruction refill, then a tie after a fresh reset, then round-robin.
        tbl.push_back(mkVec(1, 1, 0, 0, 1, 32'h104, 0, 32'h66, 32'h55, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mkVec(0, 1, 0, 0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int b = 0; b < 4; b++)
            tbl.push_back(mkVec(0, 1, 0, 0, 1, 32'h104, 0, 0, 32'hA0 + b,
                                MREQ | IGNT | IRV | BSY, 32'h100 + 4 * b, 0, 32'hA0 + b, 3'b101));
        tbl.push_back(mkVec(0, 0, 0, 0, 1, 32'h104, 0, 0, 0, IGNT | IDN | BSY, 0, 0, 0, 3'b000));
        tbl.push_back(mkVec(0, 0, 0, 0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 3'b000));

        tbl.push_back(mkVec(1, 0, 0, 0, 1, 0, 0, 32'h66, 32'h55, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mkVec(0, 1, 1, 0, 1, 32'h104, 32'h3008, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int b = 0; b < 4; b++)
            tbl.push_back(mkVec(0, 1, 1, 0, 1, 32'h104, 32'h3008, 0, 32'hB0 + b,
                                MREQ | DGNT | DRV | BSY, 32'h3000 + 4 * b, 0, 32'hB0 + b, 3'b101));
        tbl.push_back(mkVec(0, 1, 0, 0, 1, 32'h104, 32'h3008, 0, 0, DGNT | DDN | BSY, 0, 0, 0, 3'b000));
        tbl.push_back(mkVec(0, 1, 1, 0, 1, 32'h104, 32'h3008, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int b = 0; b < 4; b++)
            tbl.push_back(mkVec(0, 1, 1, 0, 1, 32'h104, 32'h3008, 0, 32'hC0 + b,
                                MREQ | IGNT | IRV | BSY, 32'h100 + 4 * b, 0, 32'hC0 + b, 3'b101));
        tbl.push_back(mkVec(0, 0, 1, 0, 1, 32'h104, 32'h3008, 0, 0, IGNT | IDN | BSY, 0, 0, 0, 3'b000));
        tbl.push_back(mkVec(0, 0, 1, 0, 1, 32'h104, 32'h3008, 0, 0, 0, 0, 0, 0, 3'b000));
        tbl.push_back(mkVec(0, 0, 1, 0, 0, 32'h104, 32'h3008, 0, 32'h99,
                            MREQ | DGNT | BSY, 32'h3000, 0, 0, 3'b100));
        tbl.push_back(mkVec(1, 0, 1, 0, 1, 32'h104, 32'h3008, 32'h66, 32'h77, 0, 0, 0, 0, 3'b111));
        tbl.push_back(mkVec(0, 0, 0, 0, 1, 32'h104, 32'h3008, 0, 0, 0, 0, 0, 0, 3'b000));

        $display("[TB] applying %0d table vectors", tbl.size());
        foreach (tbl[i]) runVec(tbl[i]);

        // Writeback with M_READY low on alternate cycles; D_REQ dropped after two beats.
        runVec(mkVec(0, 0, 1, 1, 0, 0, 32'h2000, 0, 0, 0, 0, 0, 0, 3'b000));
        beat = 0;
        for (int c = 0; c < 8; c++) begin
            rdy  = c[0];
            dReq = (beat < 2);
            wd   = 32'hD0D0_0000 | 32'(c);
            runVec(mkVec(0, 0, dReq, 1, rdy, 0, 32'h2000, wd, 32'h11,
                         MREQ | MWE | DGNT | BSY | (rdy ? WNX : 10'b0),
                         32'h2000 + 32'(4 * beat), wd, 0, 3'b110));
            if (rdy) beat++;
        end
        runVec(mkVec(0, 0, 0, 1, 1, 0, 32'h2000, 0, 0, DGNT | DDN | BSY, 0, 0, 0, 3'b000));
        runVec(mkVec(0, 0, 0, 0, 1, 0, 32'h2000, 0, 0, 0, 0, 0, 0, 3'b000));

        // Reset after beat 1 of an instruction refill, then a clean restart at beat 0.
        runVec(mkVec(0, 1, 0, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int b = 0; b < 2; b++)
            runVec(mkVec(0, 1, 0, 0, 1, 32'h44, 0, 0, 32'hE0 + b,
                         MREQ | IGNT | IRV | BSY, 32'h40 + 4 * b, 0, 32'hE0 + b, 3'b101));
        runVec(mkVec(1, 1, 0, 0, 1, 32'h44, 0, 32'h66, 32'hE2, 0, 0, 0, 0, 3'b111));
        runVec(mkVec(0, 1, 0, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 3'b000));
        for (int b = 0; b < 4; b++)
            runVec(mkVec(0, 1, 0, 0, 1, 32'h44, 0, 0, 32'hF0 + b,
                         MREQ | IGNT | IRV | BSY, 32'h40 + 4 * b, 0, 32'hF0 + b, 3'b101));
        runVec(mkVec(0, 0, 0, 0, 1, 32'h44, 0, 0, 0, IGNT | IDN | BSY, 0, 0, 0, 3'b000));
        runVec(mkVec(0, 0, 0, 0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 0, 3'b000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
